// File: rtl/multi_channel_sampler.sv
// multi_channel_sampler: synchronises NUM_CH comparator pairs and packs strobed samples into per-channel words
module multi_channel_sampler #(
    parameter int NUM_CH      = 5,
    parameter int SYNC_STAGES = 5,
    parameter int PACK        = 4,
    parameter int WCNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     smpl_en,
    input  logic [NUM_CH-1:0]        ch_h,
    input  logic [NUM_CH-1:0]        ch_l,
    output logic [NUM_CH-1:0]        ch_h_sync,
    output logic [NUM_CH-1:0]        ch_l_sync,
    output logic [NUM_CH*2*PACK-1:0] smpl_word,
    output logic                     word_vld,
    output logic [WCNT_W-1:0]        word_cnt
);
    localparam int SW = 2 * PACK;
    localparam int CW = PACK > 1 ? $clog2(PACK) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t               state, state_nx;
    logic [NUM_CH-1:0]    h_pipe [SYNC_STAGES];
    logic [NUM_CH-1:0]    l_pipe [SYNC_STAGES];
    logic [SW-1:0]        sh     [NUM_CH];
    logic [SW-1:0]        sh_nx  [NUM_CH];
    logic [NUM_CH*SW-1:0] word_nx;
    logic [CW-1:0]        pcnt;
    logic                 enter, abort, take, done;

    assign ch_h_sync = h_pipe[SYNC_STAGES-1];
    assign ch_l_sync = l_pipe[SYNC_STAGES-1];

    // Free-running synchroniser chains, independent of run and smpl_en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                h_pipe[s] <= '0;
                l_pipe[s] <= '0;
            end
        end else begin
            h_pipe[0] <= ch_h;
            l_pipe[0] <= ch_l;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                h_pipe[s] <= h_pipe[s-1];
                l_pipe[s] <= l_pipe[s-1];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end

    // Next state and capture controls; samples only count while run is still high
    always_comb begin
        state_nx = run ? FILL : IDLE;
        enter    = (state == IDLE) && run;
        abort    = (state == FILL) && !run;
        take     = (state == FILL) && run && smpl_en;
        done     = take && (pcnt == CW'(PACK - 1));
    end

    // Shift each channel left by one {H,L} sample and gather the would-be word
    always_comb begin
        word_nx = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            sh_nx[n]              = SW'({sh[n], ch_h_sync[n], ch_l_sync[n]});
            word_nx[n*SW +: SW]   = sh_nx[n];
        end
    end

    // Pack shift registers and sample counter; entry or abort discards a partial word
    always_ff @(posedge clk) begin
        if (!rst_n || enter || abort) begin
            pcnt <= '0;
            for (int n = 0; n < NUM_CH; n++) sh[n] <= '0;
        end else if (take) begin
            pcnt <= done ? '0 : pcnt + 1'b1;
            for (int n = 0; n < NUM_CH; n++) sh[n] <= sh_nx[n];
        end
    end

    // Word output, valid strobe and saturating word counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smpl_word <= '0;
            word_vld  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            word_vld <= done;
            if (done) smpl_word <= word_nx;
            if (enter) word_cnt <= '0;
            else if (done && word_cnt != '1) word_cnt <= word_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_channel_sampler.sv
// tb_multi_channel_sampler: directed checks of sync latency, packing, abort, collision and saturation
module tb_multi_channel_sampler;
    logic        clk, rst_n, run, smpl_en;
    logic [1:0]  ch_h, ch_l;
    logic [1:0]  h_sync, l_sync, s_hsync, s_lsync;
    logic [15:0] word;
    logic [15:0] cnt;
    logic        vld, s_vld;
    logic [3:0]  s_word;
    logic [2:0]  s_cnt;
    int          passed = 0, total = 0, fails = 0;
    int          vld_n = 0, s_vld_n = 0, last, bad;

    multi_channel_sampler #(.NUM_CH(2), .SYNC_STAGES(5), .PACK(4), .WCNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .smpl_en(smpl_en),
        .ch_h(ch_h), .ch_l(ch_l), .ch_h_sync(h_sync), .ch_l_sync(l_sync),
        .smpl_word(word), .word_vld(vld), .word_cnt(cnt)
    );

    multi_channel_sampler #(.NUM_CH(2), .SYNC_STAGES(2), .PACK(1), .WCNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .run(run), .smpl_en(smpl_en),
        .ch_h(ch_h), .ch_l(ch_l), .ch_h_sync(s_hsync), .ch_l_sync(s_lsync),
        .smpl_word(s_word), .word_vld(s_vld), .word_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (vld) vld_n++;
            if (s_vld) s_vld_n++;
        end
    endtask

    logic [1:0] seq2 [4];

    initial begin
        seq2 = '{2'b10, 2'b11, 2'b01, 2'b00};
        rst_n = 0; run = 0; smpl_en = 0; ch_h = 0; ch_l = 0;
        cyc(2);
        chk("rst_hsync", h_sync, 0);
        chk("rst_lsync", l_sync, 0);
        chk("rst_word", word, 0);
        chk("rst_vld", vld, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_sat_cnt", s_cnt, 0);
        rst_n = 1;
        cyc(3);
        ch_h[0] = 1;
        cyc(4);
        chk("sync_lat4", h_sync[0], 0);
        cyc(1);
        chk("sync_lat5", h_sync[0], 1);
        ch_h = 0;
        cyc(6);
        // packing order
        run = 1;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) {ch_h[0], ch_l[0]} = seq2[i];
            smpl_en = (i >= 5);
            cyc(1);
        end
        chk("pack_vld_early", vld, 0);
        cyc(1);
        smpl_en = 0;
        chk("pack_vld", vld, 1);
        chk("pack_word", word, 16'h00B4);
        chk("pack_cnt", cnt, 1);
        cyc(1);
        chk("pack_vld_pulse", vld, 0);
        // decimated rate
        run = 0; ch_h = 2'b01; ch_l = 2'b10;
        cyc(1);
        run = 1;
        cyc(6);
        vld_n = 0; last = -1; bad = 0;
        for (int c = 0; c < 132; c++) begin
            smpl_en = (c < 128) && (c % 4 == 3);
            cyc(1);
            if (vld) begin
                if (last >= 0 && c - last != 16) bad++;
                last = c;
            end
        end
        smpl_en = 0;
        chk("dec_pulses", vld_n, 8);
        chk("dec_gaps", bad, 0);
        chk("dec_cnt", cnt, 8);
        chk("dec_word", word, 16'h55AA);
        // abort mid-word
        run = 0; ch_h = 2'b01; ch_l = 2'b01;
        cyc(6);
        run = 1;
        cyc(1);
        vld_n = 0;
        smpl_en = 1;
        cyc(3);
        smpl_en = 0; run = 0;
        cyc(1);
        ch_h = 2'b00; ch_l = 2'b01;
        cyc(6);
        run = 1;
        cyc(1);
        smpl_en = 1;
        cyc(4);
        smpl_en = 0;
        cyc(2);
        chk("abort_pulses", vld_n, 1);
        chk("abort_word", word, 16'h0055);
        chk("abort_cnt", cnt, 1);
        // collision of run falling with the completing sample
        ch_h = 2'b01; ch_l = 2'b00;
        cyc(6);
        vld_n = 0;
        smpl_en = 1;
        cyc(3);
        run = 0;
        cyc(1);
        smpl_en = 0;
        cyc(2);
        chk("coll_pulses", vld_n, 0);
        chk("coll_word", word, 16'h0055);
        chk("coll_cnt", cnt, 1);
        // saturation with PACK=1 back-to-back words
        run = 1;
        cyc(1);
        vld_n = 0; s_vld_n = 0;
        smpl_en = 1;
        cyc(10);
        smpl_en = 0;
        cyc(2);
        chk("sat_pulses", s_vld_n, 10);
        chk("sat_cnt", s_cnt, 7);
        chk("sat_word", s_word, 4'b0010);
        chk("b2b_main_pulses", vld_n, 2);
        chk("b2b_main_cnt", cnt, 2);
        // reset mid-word clears everything
        smpl_en = 1;
        cyc(2);
        rst_n = 0; smpl_en = 0;
        cyc(1);
        chk("rst2_word", word, 0);
        chk("rst2_cnt", cnt, 0);
        chk("rst2_sat_cnt", s_cnt, 0);
        chk("rst2_hsync", h_sync, 0);
        rst_n = 1; run = 0;
        cyc(1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/multi_channel_sampler.md
Name: multi_channel_sampler

Overview:
Parametrised successor to the single-channel sampler. It synchronises NUM_CH pairs of AFE comparator outputs (CHxH/CHxL) through a configurable flop chain, all in the single 100MHz `clk` domain. Sampling is qualified by a one-cycle `smpl_en` strobe from clk_rst_smpl, which replaces the separate sample clock. Successive samples are packed into per-channel words, and a one-cycle valid strobe marks each completed word for the capture RAM and trigger logic. The block sits between the AFE inputs and the RAM/trigger units.

Parameters:
NUM_CH, 5, number of channels sampled in parallel.
SYNC_STAGES, 5, synchroniser flop stages per input bit (minimum 2).
PACK, 4, samples packed per word; each sample is 2 bits {H,L}.
WCNT_W, 16, width of the word counter.

Ports:
clk  in  1  system clock; all flops rise on posedge.
rst_n  in  1  reset, synchronous and active-low.
run  in  1  capture enable; level-sensitive.
smpl_en  in  1  one-cycle sample strobe (decimated rate).
ch_h  in  NUM_CH  raw CHxH comparator inputs (asynchronous).
ch_l  in  NUM_CH  raw CHxL comparator inputs (asynchronous).
ch_h_sync  out  NUM_CH  last synchroniser stage of ch_h; feeds the trigger logic.
ch_l_sync  out  NUM_CH  last synchroniser stage of ch_l.
smpl_word  out  NUM_CH*2*PACK  packed words; channel n occupies bits [n*2*PACK +: 2*PACK].
word_vld  out  1  one-cycle pulse when smpl_word is updated.
word_cnt  out  WCNT_W  number of words emitted since run rose; saturates.

Behaviour:
- Reset (rst_n=0 at posedge clk): every flop clears, including the synchroniser chain, the pack shift registers, the pack counter, smpl_word, word_vld and word_cnt. State goes to IDLE. Reset mid-word discards the partial word.
- Synchroniser:
  - Each input bit passes through SYNC_STAGES flops on every clk, independent of run and smpl_en.
  - ch_*_sync is the final stage, so an input change appears on ch_*_sync exactly SYNC_STAGES cycles later.
- State machine:
  - IDLE -> FILL when run=1. The transition takes effect next cycle; smpl_en in the cycle run rises is ignored.
  - On entry to FILL, the pack counter clears to 0 and word_cnt clears to 0.
  - FILL -> IDLE when run=0, effective next cycle. The partial word is discarded and the counter clears. smpl_en in any cycle with run=0 is ignored.
  - smpl_word and word_cnt hold their values in IDLE.
- Sampling in FILL, on a cycle with smpl_en=1:
  - Each channel's shift register shifts left by 2 and loads {ch_h_sync[n], ch_l_sync[n]} into bits [1:0]. The oldest sample therefore ends up in the MSBs, H in the odd bit and L in the even bit.
  - The pack counter increments.
- Word completion:
  - When the sample taken makes the pack counter reach PACK, the counter wraps to 0.
  - In the next cycle, smpl_word is loaded with all shift registers, word_vld=1 for exactly one cycle, and word_cnt increments.
  - Latency: from the PACK-th smpl_en cycle to word_vld is 1 cycle.
- Back-to-back operation:
  - smpl_en may be high every cycle; words then complete every PACK cycles with no lost samples.
  - With PACK=1, word_vld may be high on consecutive cycles.
- Simultaneous run=0 and a completing smpl_en: the sample is ignored and no word_vld is produced.
- word_cnt saturates at 2^WCNT_W-1 and does not wrap; word_vld continues to pulse after saturation.
- smpl_en timing: it is not required to be periodic. Gaps of any length simply stall the packing.

Test Plan:
1. Reset/sync latency (NUM_CH=2, SYNC_STAGES=5): assert rst_n=0 for 2 cycles, then step ch_h[0] 0->1 at cycle 10 -> ch_h_sync[0] rises at cycle 15; all outputs are 0 throughout reset.
2. Packing order (PACK=4): hold run=1, smpl_en every cycle, ch0 sync sequence {H,L}=10,11,01,00 -> word_vld at 4th sample+1; smpl_word[7:0]=8'b10_11_01_00; word_cnt=1.
3. Decimated rate: smpl_en every 4th cycle over 32 samples -> exactly 8 word_vld pulses, 16 cycles apart; word_cnt=8.
4. Abort mid-word: run=1, 3 samples, then run=0, then run=1, then 4 samples of 01 -> only one word_vld; smpl_word[7:0]=8'h55; word_cnt=1.
5. Collision: the 4th smpl_en coincides with run falling -> no word_vld; smpl_word unchanged from its previous value.
6. Saturation (WCNT_W=3): emit 10 words -> word_cnt stops at 7; 10 word_vld pulses observed.
